// File: rtl/icache_line_responder_if.sv
// ============================================================================
// Module : icache_line_responder_if
// Brief  : Refill request/response and word-load bundle for the ICache
//          line responder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface icache_line_responder_if;
  logic [31:0]  icache_addr_i;
  logic         icache_valid_req_i;
  logic         mem_ready_o;
  logic [127:0] mem_data_o;
  logic         busy_o;
  logic         load_en_i;
  logic [31:0]  load_addr_i;
  logic [31:0]  load_data_i;

  modport master (
    output icache_addr_i, icache_valid_req_i, load_en_i, load_addr_i, load_data_i,
    input  mem_ready_o, mem_data_o, busy_o
  );

  modport slave (
    input  icache_addr_i, icache_valid_req_i, load_en_i, load_addr_i, load_data_i,
    output mem_ready_o, mem_data_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/icache_line_responder.sv
// ============================================================================
// Module : icache_line_responder
// Brief  : Fixed-latency 128-bit line responder with a word-write load port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_line_responder #(
  parameter int unsigned LINES   = 256,
  parameter int unsigned LATENCY = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  icache_line_responder_if.slave     bus
);

  localparam int unsigned IDX_W = $clog2(LINES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  logic [127:0]     r_mem [LINES];
  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [127:0]     r_data;
  logic             r_ready;
  logic             r_busy;

  logic [IDX_W-1:0] w_req_idx;
  logic [IDX_W-1:0] w_load_idx;
  logic [6:0]       w_load_bit;
  logic             w_unused;

  assign w_req_idx  = bus.icache_addr_i[IDX_W+3:4];
  assign w_load_idx = bus.load_addr_i[IDX_W+3:4];
  assign w_load_bit = {bus.load_addr_i[3:2], 5'd0};
  assign w_unused   = ^{bus.icache_addr_i[31:IDX_W+4], bus.icache_addr_i[3:0],
                        bus.load_addr_i[31:IDX_W+4], bus.load_addr_i[1:0]};

  // Storage is deliberately not reset; non-blocking write gives read-before-write.
  always_ff @(posedge clk) begin
    if (bus.load_en_i) begin
      r_mem[w_load_idx][w_load_bit +: 32] <= bus.load_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
          r_data  <= '0;
          if (bus.icache_valid_req_i) begin
            r_idx  <= w_req_idx;
            r_cnt  <= 4'(LATENCY - 1);
            r_busy <= 1'b1;
            if (LATENCY == 1) begin
              r_data  <= r_mem[w_req_idx];
              r_ready <= 1'b1;
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!bus.icache_valid_req_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == 4'd1) begin
            r_data  <= r_mem[r_idx];
            r_ready <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_ready <= 1'b0;
          r_data  <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_data  <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_ready_o = r_ready;
  assign bus.mem_data_o  = r_data;
  assign bus.busy_o      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_icache_line_responder.sv
// ============================================================================
// Module : tb_icache_line_responder
// Brief  : Scoreboard bench for icache_line_responder at LATENCY 4 and 1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_line_responder;

  logic clk;
  logic rst;

  icache_line_responder_if ia ();
  icache_line_responder_if ib ();

  icache_line_responder #(.LINES(256), .LATENCY(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  icache_line_responder #(.LINES(256), .LATENCY(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  logic [127:0] model_a [256];
  logic [127:0] model_b [256];
  logic [127:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit sel, input bit v, input logic [31:0] addr);
    if (sel) begin
      ib.icache_valid_req_i = v;
      ib.icache_addr_i      = addr;
    end else begin
      ia.icache_valid_req_i = v;
      ia.icache_addr_i      = addr;
    end
  endtask

  task automatic get_out(input bit sel, output logic r, output logic [127:0] d, output logic b);
    r = sel ? ib.mem_ready_o : ia.mem_ready_o;
    d = sel ? ib.mem_data_o  : ia.mem_data_o;
    b = sel ? ib.busy_o      : ia.busy_o;
  endtask

  task automatic load_word(input bit sel, input logic [31:0] addr, input logic [31:0] data);
    logic [7:0] idx;
    logic [6:0] bitp;
    idx  = addr[11:4];
    bitp = {addr[3:2], 5'd0};
    if (sel) begin
      ib.load_en_i = 1'b1; ib.load_addr_i = addr; ib.load_data_i = data;
    end else begin
      ia.load_en_i = 1'b1; ia.load_addr_i = addr; ia.load_data_i = data;
    end
    tick();
    ia.load_en_i = 1'b0;
    ib.load_en_i = 1'b0;
    if (sel) model_b[idx][bitp +: 32] = data;
    else     model_a[idx][bitp +: 32] = data;
  endtask

  // One full request: pulse must land exactly LATENCY cycles after the drive cycle.
  task automatic read_line(input bit sel, input logic [31:0] addr, input string name);
    int lat;
    bit seen;
    logic r, b;
    logic [127:0] d, e;
    lat = sel ? 1 : 4;
    exp_q.push_back(sel ? model_b[addr[11:4]] : model_a[addr[11:4]]);
    set_req(sel, 1'b1, addr);
    seen = 1'b0;
    for (int i = 1; i <= lat + 3 && !seen; i++) begin
      tick();
      get_out(sel, r, d, b);
      if (r) begin
        seen = 1'b1;
        set_req(sel, 1'b0, addr);
        total++;
        if (i != lat) begin
          bad++;
          $display("FAIL %s latency: got %0d want %0d", name, i, lat);
        end
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin
          bad++;
          $display("FAIL %s data: got %h want %h", name, d, e);
        end
      end else begin
        total++;
        if (d !== 128'd0) begin
          bad++;
          $display("FAIL %s data before pulse: got %h want 0", name, d);
        end
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s timeout: got no pulse want pulse", name);
      set_req(sel, 1'b0, addr);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    tick();
    get_out(sel, r, d, b);
    total++;
    if (r !== 1'b0 || d !== 128'd0 || b !== 1'b0) begin
      bad++;
      $display("FAIL %s after: got r=%b b=%b d=%h want 0 0 0", name, r, b, d);
    end
  endtask

  task automatic test_reset();
    logic r, b;
    logic [127:0] d;
    rst = 1'b1;
    set_req(0, 1'b0, 32'd0); set_req(1, 1'b0, 32'd0);
    ia.load_en_i = 1'b0; ia.load_addr_i = '0; ia.load_data_i = '0;
    ib.load_en_i = 1'b0; ib.load_addr_i = '0; ib.load_data_i = '0;
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      get_out(s[0], r, d, b);
      total++;
      if (r !== 1'b0 || d !== 128'd0 || b !== 1'b0) begin
        bad++;
        $display("FAIL reset_state dut%0d: got r=%b b=%b d=%h want 0 0 0", s, r, b, d);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    load_word(0, 32'h30, 32'h11111111);
    load_word(0, 32'h34, 32'h22222222);
    load_word(0, 32'h38, 32'h33333333);
    load_word(0, 32'h3C, 32'h44444444);
    total++;
    if (model_a[3] !== 128'h44444444_33333333_22222222_11111111) begin
      bad++;
      $display("FAIL basic_model: got %h want fixed line", model_a[3]);
    end
    read_line(0, 32'h00000038, "basic");
  endtask

  task automatic test_wrap();
    logic r, b;
    logic [127:0] d;
    load_word(0, 32'h0, 32'hDEADBEEF);
    load_word(0, 32'h4, 32'h01020304);
    load_word(0, 32'h8, 32'h05060708);
    load_word(0, 32'hC, 32'h090A0B0C);
    read_line(0, 32'h00001000, "wrap");
    // Second pass checks the low word explicitly against the loaded constant.
    set_req(0, 1'b1, 32'h00001000);
    for (int i = 0; i < 4; i++) tick();
    set_req(0, 1'b0, 32'h0);
    get_out(0, r, d, b);
    total++;
    if (r !== 1'b1 || d[31:0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wrap_word0: got r=%b w=%h want 1 deadbeef", r, d[31:0]);
    end
    tick();
  endtask

  task automatic test_abort();
    logic r, b;
    logic [127:0] d;
    set_req(0, 1'b1, 32'h30);
    tick();
    get_out(0, r, d, b);
    total++;
    if (b !== 1'b1) begin
      bad++;
      $display("FAIL abort_busy_on: got %b want 1", b);
    end
    tick();
    set_req(0, 1'b0, 32'h30);
    tick();
    get_out(0, r, d, b);
    total++;
    if (b !== 1'b0 || r !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy_off: got b=%b r=%b want 0 0", b, r);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      get_out(0, r, d, b);
      total++;
      if (r !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_pulse: got %b want 0", r);
      end
    end
    read_line(0, 32'h3C, "abort_retry");
  endtask

  task automatic test_held();
    logic r, b, want;
    logic [127:0] d, e;
    load_word(0, 32'h70, 32'hA0A0A0A0);
    load_word(0, 32'h74, 32'hB1B1B1B1);
    load_word(0, 32'h78, 32'hC2C2C2C2);
    load_word(0, 32'h7C, 32'hD3D3D3D3);
    exp_q.push_back(model_a[3]);
    exp_q.push_back(model_a[7]);
    set_req(0, 1'b1, 32'h30);
    for (int i = 1; i <= 12; i++) begin
      tick();
      get_out(0, r, d, b);
      if (i == 2) ia.icache_addr_i = 32'h70;
      want = (i == 4 || i == 9);
      total++;
      if (r !== want) begin
        bad++;
        $display("FAIL held_pulse cycle %0d: got %b want %b", i, r, want);
      end
      if (r === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin
          bad++;
          $display("FAIL held_data cycle %0d: got %h want %h", i, d, e);
        end
      end
      if (i == 12) set_req(0, 1'b0, 32'h70);
    end
    tick();
    get_out(0, r, d, b);
    total++;
    if (b !== 1'b0 || r !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL held_end: got b=%b r=%b q=%0d want 0 0 0", b, r, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic r, b;
    logic [127:0] d;
    set_req(0, 1'b1, 32'h30);
    tick(); tick();
    rst = 1'b1; set_req(0, 1'b0, 32'h30);
    tick();
    get_out(0, r, d, b);
    total++;
    if (r !== 1'b0 || d !== 128'd0 || b !== 1'b0) begin
      bad++;
      $display("FAIL reset_wait: got r=%b b=%b d=%h want 0 0 0", r, b, d);
    end
    rst = 1'b0;
    // Reset sampled on the edge that would enter RESP must suppress the pulse.
    set_req(0, 1'b1, 32'h30);
    tick(); tick(); tick();
    rst = 1'b1; set_req(0, 1'b0, 32'h30);
    tick();
    get_out(0, r, d, b);
    total++;
    if (r !== 1'b0 || d !== 128'd0 || b !== 1'b0) begin
      bad++;
      $display("FAIL reset_resp: got r=%b b=%b d=%h want 0 0 0", r, b, d);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      get_out(0, r, d, b);
      total++;
      if (r !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_pulse: got %b want 0", r);
      end
    end
    read_line(0, 32'h34, "reset_preserve");
  endtask

  task automatic test_lat1_collision();
    logic r, b;
    logic [127:0] d, e;
    load_word(1, 32'h50, 32'h50505050);
    load_word(1, 32'h54, 32'h54545454);
    load_word(1, 32'h58, 32'h58585858);
    load_word(1, 32'h5C, 32'h5C5C5C5C);
    exp_q.push_back(model_b[5]);
    set_req(1, 1'b1, 32'h50);
    ib.load_en_i = 1'b1; ib.load_addr_i = 32'h50; ib.load_data_i = 32'h55555555;
    tick();
    ib.load_en_i = 1'b0;
    model_b[5][31:0] = 32'h55555555;
    set_req(1, 1'b0, 32'h50);
    get_out(1, r, d, b);
    e = exp_q.pop_front();
    total++;
    if (r !== 1'b1 || d !== e) begin
      bad++;
      $display("FAIL lat1_old: got r=%b d=%h want 1 %h", r, d, e);
    end
    tick();
    read_line(1, 32'h50, "lat1_new");
  endtask

  task automatic test_back_to_back();
    logic r, b, want;
    logic [127:0] d, e;
    for (int k = 0; k < 3; k++) exp_q.push_back(model_b[5]);
    set_req(1, 1'b1, 32'h5C);
    for (int i = 1; i <= 6; i++) begin
      tick();
      get_out(1, r, d, b);
      want = i[0];
      total++;
      if (r !== want) begin
        bad++;
        $display("FAIL b2b_pulse cycle %0d: got %b want %b", i, r, want);
      end
      if (r === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin
          bad++;
          $display("FAIL b2b_data cycle %0d: got %h want %h", i, d, e);
        end
      end
      if (i == 6) set_req(1, 1'b0, 32'h5C);
    end
    tick();
    get_out(1, r, d, b);
    total++;
    if (b !== 1'b0 || r !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_end: got b=%b r=%b q=%0d want 0 0 0", b, r, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_abort();
    test_held();
    test_reset_mid();
    test_lat1_collision();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
